// File: rtl/get_data_capture_ctrl_if.sv
// Capture-controller bus: control word, sample stream, BRAM write port, status.
// Latency: n/a (signal bundle only).
// Backpressure: none; data_valid qualifies samples, the BRAM port cannot stall.
//
// master drives ctrl_word/sync_in/data_in/data_valid and observes the rest;
// slave (the controller) is the opposite side.
interface get_data_capture_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
);
    logic [31:0]       ctrl_word;
    logic              sync_in;
    logic [DATA_W-1:0] data_in;
    logic              data_valid;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_din;
    logic              bram_we;
    logic [31:0]       status_word;
    logic              done_pulse;

    modport master (
        output ctrl_word, sync_in, data_in, data_valid,
        input  bram_addr, bram_din, bram_we, status_word, done_pulse
    );

    modport slave (
        input  ctrl_word, sync_in, data_in, data_valid,
        output bram_addr, bram_din, bram_we, status_word, done_pulse
    );
endinterface

// File: rtl/get_data_capture_ctrl.sv
// Arm / sync-triggered snapshot capture of N valid samples into a BRAM.
// Latency: accepted sample reaches the BRAM write port one cycle later.
// Backpressure: none; samples are accepted whenever data_valid is high while capturing.
//
// Ports: user_clk, user_rst_n (async, active-low), bus (slave modport):
//   ctrl_word [0] arm (rising edge), [1] abort (level), [31:16] sample count N
//   sync_in, data_in, data_valid            sample stream and trigger
//   bram_addr, bram_din, bram_we            snapshot write port
//   status_word [0] armed [1] capturing [2] done [3] timeout [31:16] samples written
//   done_pulse                              one cycle, coincides with the final write
// Optional macro GET_DATA_TIMEOUT_EN: ARMED gives up after TIMEOUT_CYC cycles without sync.
module get_data_capture_ctrl #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 10,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic                    user_clk,
    input  logic                    user_rst_n,
    get_data_capture_ctrl_if.slave  bus
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ARMED   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    // Count needs one extra bit so a full buffer (2^ADDR_W) is representable.
    localparam int               CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    logic [1:0]        state;
    logic [31:0]       ctrl_q;
    logic              ctrl_prev;
    logic [CNT_W-1:0]  len_q;
    logic [CNT_W-1:0]  len_next;
    logic [CNT_W-1:0]  acc_cnt;
    logic [CNT_W-1:0]  acc_inc;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] din_q;
    logic              pulse_q;
    logic              done_q;
    logic              tmo_flag;
    logic              tmo_fire;

    logic arm_edge;
    logic abort;
    logic arm_go;
    logic accept;
    logic last;
    logic unused_ctrl_bits;

    assign unused_ctrl_bits = ^ctrl_q[15:2];

    assign abort    = ctrl_q[1];
    assign arm_edge = ctrl_q[0] & ~ctrl_prev;
    assign arm_go   = arm_edge & ~abort & ((state == S_IDLE) | (state == S_DONE));

    // The sync cycle itself may carry sample 0.
    assign accept  = bus.data_valid & ~abort &
                     (((state == S_ARMED) & bus.sync_in) | (state == S_CAPTURE));
    assign acc_inc = acc_cnt + CNT_W'(1);
    assign last    = accept & (acc_inc == len_q);

    // N=0 and oversize N both mean "fill the whole buffer".
    always_comb begin
        len_next = CNT_W'(ctrl_q[31:16]);
        if ((ctrl_q[31:16] == 16'd0) || ({16'd0, ctrl_q[31:16]} > 32'(DEPTH)))
            len_next = DEPTH;
    end

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            ctrl_q    <= '0;
            ctrl_prev <= 1'b0;
            state     <= S_IDLE;
            len_q     <= '0;
            acc_cnt   <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            din_q     <= '0;
            pulse_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            ctrl_q    <= bus.ctrl_word;
            ctrl_prev <= ctrl_q[0];

            we_q    <= accept;
            pulse_q <= last | tmo_fire;
            if (accept) begin
                addr_q  <= acc_cnt[ADDR_W-1:0];
                din_q   <= bus.data_in;
                acc_cnt <= acc_inc;
            end

            // done follows the pulse by one cycle; an abort landing in that
            // cycle suppresses it.
            if (arm_go)
                done_q <= 1'b0;
            else if (pulse_q && !abort)
                done_q <= 1'b1;

            if (arm_go) begin
                len_q   <= len_next;
                acc_cnt <= '0;
            end

            if (abort) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE, S_DONE: if (arm_edge) state <= S_ARMED;
                    S_ARMED: begin
                        if (bus.sync_in)
                            state <= last ? S_DONE : S_CAPTURE;
                        else if (tmo_fire)
                            state <= S_DONE;
                    end
                    S_CAPTURE: if (last) state <= S_DONE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

`ifdef GET_DATA_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_cnt;

    // sync_in in the terminal cycle takes precedence over the timeout.
    assign tmo_fire = (state == S_ARMED) & ~bus.sync_in & ~abort &
                      (tmo_cnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            tmo_cnt  <= '0;
            tmo_flag <= 1'b0;
        end else if (arm_go) begin
            tmo_cnt  <= '0;
            tmo_flag <= 1'b0;
        end else if (tmo_fire) begin
            tmo_flag <= 1'b1;
        end else if (state == S_ARMED) begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end
`else
    assign tmo_fire = 1'b0;
    assign tmo_flag = 1'b0;
`endif

    assign bus.bram_we     = we_q;
    assign bus.bram_addr   = addr_q;
    assign bus.bram_din    = din_q;
    assign bus.done_pulse  = pulse_q;
    assign bus.status_word = {16'(acc_cnt), 12'd0, tmo_flag, done_q,
                              state == S_CAPTURE, state == S_ARMED};
endmodule

// File: tb/tb_get_data_capture_ctrl.sv
// Directed bench for get_data_capture_ctrl (ADDR_W=4, TIMEOUT_CYC=20).
// Latency: n/a.
// Backpressure: n/a.
module tb_get_data_capture_ctrl;
    localparam int DATA_W      = 32;
    localparam int ADDR_W      = 4;
    localparam int TIMEOUT_CYC = 20;

    logic user_clk   = 1'b0;
    logic user_rst_n = 1'b0;
    always #5 user_clk = ~user_clk;

    get_data_capture_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    get_data_capture_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .user_clk  (user_clk),
        .user_rst_n(user_rst_n),
        .bus       (bus.slave)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Write monitor: every BRAM write with its cycle and the done_pulse level.
    int          cyc = 0;
    int          wr_cyc[$];
    logic [31:0] wr_addr[$];
    logic [31:0] wr_dat[$];
    logic        wr_pls[$];
    int          pulse_cnt = 0;
    int          sync_cyc = 0;

    always @(posedge user_clk) cyc <= cyc + 1;

    always @(negedge user_clk) begin
        if (user_rst_n) begin
            if (bus.bram_we) begin
                wr_cyc.push_back(cyc);
                wr_addr.push_back(32'(bus.bram_addr));
                wr_dat.push_back(bus.bram_din);
                wr_pls.push_back(bus.done_pulse);
            end
            if (bus.done_pulse) pulse_cnt++;
        end
    end

    task automatic clear_mon();
        wr_cyc.delete(); wr_addr.delete(); wr_dat.delete(); wr_pls.delete();
        pulse_cnt = 0;
    endtask

    task automatic tick();
        @(posedge user_clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic arm(input logic [15:0] n);
        bus.ctrl_word = {n, 14'd0, 2'b01};
        idle(2);
        bus.ctrl_word[0] = 1'b0;
    endtask

    // Bit i of vmask is data_valid in cycle i; data is base+i.
    task automatic samples(input logic do_sync, input logic [31:0] vmask,
                           input int ncyc, input logic [31:0] base);
        for (int i = 0; i < ncyc; i++) begin
            if (i == 0) sync_cyc = cyc;
            bus.sync_in    = do_sync && (i == 0);
            bus.data_valid = vmask[i];
            bus.data_in    = base + 32'(i);
            tick();
        end
        bus.sync_in    = 1'b0;
        bus.data_valid = 1'b0;
    endtask

    function automatic logic [31:0] wa(input int i);
        return (i < wr_addr.size()) ? wr_addr[i] : 32'hDEAD_BEEF;
    endfunction
    function automatic logic [31:0] wd(input int i);
        return (i < wr_dat.size()) ? wr_dat[i] : 32'hDEAD_BEEF;
    endfunction
    function automatic logic [31:0] wp(input int i);
        return (i < wr_pls.size()) ? 32'(wr_pls[i]) : 32'hDEAD_BEEF;
    endfunction
    function automatic logic [31:0] wc(input int i);
        return (i < wr_cyc.size()) ? 32'(wr_cyc[i] - sync_cyc) : 32'hDEAD_BEEF;
    endfunction

    initial begin
        bus.ctrl_word  = '0;
        bus.sync_in    = 1'b0;
        bus.data_in    = '0;
        bus.data_valid = 1'b0;

        #12;
        check("rst_status", bus.status_word, 32'h0);
        check("rst_we",     32'(bus.bram_we), 32'h0);
        check("rst_pulse",  32'(bus.done_pulse), 32'h0);
        @(negedge user_clk);
        user_rst_n = 1'b1;
        tick();

        // N=4, continuous valid
        arm(16'd4);
        check("t1_armed", bus.status_word, 32'h0000_0001);
        clear_mon();
        samples(1'b1, 32'h0000_000F, 4, 32'hA0);
        idle(2);
        check("t1_nwr", 32'(wr_addr.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t1_addr%0d", i), wa(i), 32'(i));
            check($sformatf("t1_dat%0d", i),  wd(i), 32'hA0 + 32'(i));
        end
        check("t1_first_lat", wc(0), 32'd1);
        check("t1_pls_early", wp(2), 32'd0);
        check("t1_pls_last",  wp(3), 32'd1);
        check("t1_npulse", 32'(pulse_cnt), 32'd1);
        check("t1_status", bus.status_word, 32'h0004_0004);

        // N=3, valid 1,0,0,1,1
        arm(16'd3);
        clear_mon();
        samples(1'b1, 32'h0000_0019, 5, 32'hB0);
        idle(2);
        check("t2_nwr", 32'(wr_addr.size()), 32'd3);
        check("t2_dat0", wd(0), 32'hB0);
        check("t2_dat1", wd(1), 32'hB3);
        check("t2_dat2", wd(2), 32'hB4);
        check("t2_addr2", wa(2), 32'd2);
        check("t2_cyc1", wc(1), 32'd4);
        check("t2_cyc2", wc(2), 32'd5);
        check("t2_pls", wp(2), 32'd1);
        check("t2_status", bus.status_word, 32'h0003_0004);

        // N=0 and N=0xFFFF fill the 16-entry buffer
        arm(16'd0);
        clear_mon();
        samples(1'b1, 32'hFFFF_FFFF, 20, 32'hC0);
        idle(2);
        check("t3a_nwr", 32'(wr_addr.size()), 32'd16);
        check("t3a_last_addr", wa(15), 32'd15);
        check("t3a_last_dat", wd(15), 32'hCF);
        check("t3a_npulse", 32'(pulse_cnt), 32'd1);
        check("t3a_status", bus.status_word, 32'h0010_0004);

        arm(16'hFFFF);
        clear_mon();
        samples(1'b1, 32'hFFFF_FFFF, 20, 32'hD0);
        idle(2);
        check("t3b_nwr", 32'(wr_addr.size()), 32'd16);
        check("t3b_last_addr", wa(15), 32'd15);
        check("t3b_status", bus.status_word, 32'h0010_0004);

        // Abort after 2 of 8 samples
        arm(16'd8);
        clear_mon();
        samples(1'b1, 32'h0000_0003, 2, 32'hE0);
        bus.ctrl_word[1] = 1'b1;
        idle(3);
        check("t4_status", bus.status_word, 32'h0002_0000);
        check("t4_nwr", 32'(wr_addr.size()), 32'd2);
        check("t4_npulse", 32'(pulse_cnt), 32'd0);
        bus.ctrl_word[0] = 1'b1;
        idle(3);
        check("t4_arm_blocked", bus.status_word, 32'h0002_0000);
        bus.ctrl_word[1:0] = 2'b00;
        idle(3);
        arm(16'd8);
        check("t4_rearm", bus.status_word, 32'h0000_0001);

        // Arm edge during CAPTURE is ignored
        clear_mon();
        samples(1'b1, 32'h0000_0003, 2, 32'hF0);
        bus.ctrl_word[0] = 1'b1;
        idle(2);
        bus.ctrl_word[0] = 1'b0;
        idle(2);
        check("t5_capt_arm", bus.status_word, 32'h0002_0002);
        samples(1'b0, 32'h0000_003F, 6, 32'hF2);
        idle(2);
        check("t5_nwr", 32'(wr_addr.size()), 32'd8);
        check("t5_last_dat", wd(7), 32'hF7);
        check("t5_status", bus.status_word, 32'h0008_0004);
        arm(16'd4);
        check("t5_done_rearm", bus.status_word, 32'h0000_0001);

        // Async reset mid-capture
        bus.sync_in = 1'b1; bus.data_valid = 1'b1; bus.data_in = 32'h55;
        tick();
        bus.sync_in = 1'b0; bus.data_valid = 1'b0;
        check("t6_pre_we", 32'(bus.bram_we), 32'd1);
        #2 user_rst_n = 1'b0;
        #1;
        check("t6_rst_status", bus.status_word, 32'h0);
        check("t6_rst_we",     32'(bus.bram_we), 32'h0);
        check("t6_rst_addr",   32'(bus.bram_addr), 32'h0);
        check("t6_rst_din",    bus.bram_din, 32'h0);
        @(negedge user_clk);
        user_rst_n = 1'b1;
        tick();

        // ARMED with no sync
        arm(16'd4);
        clear_mon();
        idle(30);
`ifdef GET_DATA_TIMEOUT_EN
        check("t7_status", bus.status_word, 32'h0000_000C);
        check("t7_npulse", 32'(pulse_cnt), 32'd1);
`else
        check("t7_status", bus.status_word, 32'h0000_0001);
        check("t7_npulse", 32'(pulse_cnt), 32'd0);
`endif
        check("t7_nwr", 32'(wr_addr.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
